// File: rtl/router_pkg.sv
// Shared types and header layout for the router packet transmitter.
// Optional build macro used by router_pkt_tx: ROUTER_TX_ERR_INJ_EN.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        HEADER  = 3'd2,
        PAYLOAD = 3'd3,
        PARITY  = 3'd4,
        GAP     = 3'd5
    } state_t;

    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    localparam int MAX_LEN_LIMIT = 63;

    // Header byte as the router expects it: length in the upper six bits.
    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] h;
        h = '0;
        h[LEN_MSB:LEN_LSB]   = len;
        h[ADDR_MSB:ADDR_LSB] = addr;
        return h;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// 64x8 payload buffer: synchronous write, combinational read, contents survive reset.
module router_tx_buf (
    input  logic       clock,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [0:63];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Byte-serial packet source for the 1x3 router: header, buffered payload, even XOR parity.
// Build macro ROUTER_TX_ERR_INJ_EN adds inject_err to corrupt bit 0 of the parity byte.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
`ifdef ROUTER_TX_ERR_INJ_EN
    input  logic       inject_err,
`endif
    input  logic [1:0] dest_addr,
    input  logic [5:0] payload_len,
    output logic       start_ready,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       done,
    output logic       err,
    output logic [2:0] dbg_state
);

    localparam int LEN_CAP = (MAX_LEN > MAX_LEN_LIMIT) ? MAX_LEN_LIMIT : MAX_LEN;
    localparam int GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Handshakes: a start is taken on a rising edge with start && start_ready; a
    // payload byte is written on pl_valid && pl_ready; an output byte is
    // transferred on any edge in HEADER/PAYLOAD/PARITY with busy low, otherwise held.

    state_t          state, state_d;
    logic [5:0]      wr_cnt, wr_cnt_d;
    logic [5:0]      rd_cnt, rd_cnt_d;
    logic [GW-1:0]   gap_cnt, gap_cnt_d;
    logic [5:0]      len_q, len_d;
    logic [1:0]      addr_q, addr_d;
    logic            inj_q, inj_d;
    logic            inj_in;
    logic [7:0]      parity_q, parity_d;
    logic [7:0]      data_out_d;
    logic            pkt_valid_d;
    logic            done_d;
    logic            err_d;
    logic            buf_we;
    logic [5:0]      rd_addr;
    logic [7:0]      rd_data;

`ifdef ROUTER_TX_ERR_INJ_EN
    assign inj_in = inject_err;
`else
    assign inj_in = 1'b0;
`endif

    router_tx_buf u_buf (
        .clock   (clock),
        .wr_en   (buf_we),
        .wr_addr (wr_cnt),
        .wr_data (pl_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            gap_cnt   <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            inj_q     <= 1'b0;
            parity_q  <= '0;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            wr_cnt    <= wr_cnt_d;
            rd_cnt    <= rd_cnt_d;
            gap_cnt   <= gap_cnt_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            inj_q     <= inj_d;
            parity_q  <= parity_d;
            data_out  <= data_out_d;
            pkt_valid <= pkt_valid_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d     = state;
        wr_cnt_d    = wr_cnt;
        rd_cnt_d    = rd_cnt;
        gap_cnt_d   = gap_cnt;
        len_d       = len_q;
        addr_d      = addr_q;
        inj_d       = inj_q;
        parity_d    = parity_q;
        data_out_d  = data_out;
        pkt_valid_d = pkt_valid;
        done_d      = 1'b0;
        err_d       = 1'b0;
        buf_we      = 1'b0;
        rd_addr     = rd_cnt + 6'd1;
        start_ready = 1'b0;
        pl_ready    = 1'b0;

        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start) begin
                    len_d  = payload_len;
                    addr_d = dest_addr;
                    inj_d  = inj_in;
                    if (dest_addr == ADDR_ILLEGAL || payload_len == 6'd0 ||
                        payload_len > 6'(LEN_CAP)) begin
                        err_d = 1'b1;
                    end else begin
                        wr_cnt_d = '0;
                        state_d  = LOAD;
                    end
                end
            end

            LOAD: begin
                pl_ready = 1'b1;
                if (pl_valid) begin
                    buf_we   = 1'b1;
                    wr_cnt_d = wr_cnt + 6'd1;
                    // Header goes out on the very edge that stores the last byte.
                    if (wr_cnt == len_q - 6'd1) begin
                        data_out_d  = make_header(len_q, addr_q);
                        parity_d    = make_header(len_q, addr_q);
                        pkt_valid_d = 1'b1;
                        state_d     = HEADER;
                    end
                end
            end

            HEADER: begin
                rd_addr = 6'd0;
                if (!busy) begin
                    data_out_d = rd_data;
                    rd_cnt_d   = '0;
                    state_d    = PAYLOAD;
                end
            end

            PAYLOAD: begin
                if (!busy) begin
                    parity_d = parity_q ^ data_out;
                    if (rd_cnt == len_q - 6'd1) begin
                        data_out_d  = parity_q ^ data_out ^ {7'b0, inj_q};
                        pkt_valid_d = 1'b0;
                        state_d     = PARITY;
                    end else begin
                        data_out_d = rd_data;
                        rd_cnt_d   = rd_cnt + 6'd1;
                    end
                end
            end

            PARITY: begin
                if (!busy) begin
                    data_out_d = '0;
                    done_d     = 1'b1;
                    gap_cnt_d  = '0;
                    state_d    = GAP;
                end
            end

            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbg_state = state;

endmodule
